// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl -- tic-tac-toe game sequencer in front of the board storage block.
//
// Takes move requests from the human player (X) and the CPU opponent (O).
// Serves only the side whose turn the board reports. Refuses out-of-range or
// occupied-cell moves. Drives the board's update_loc/submit/reset strobes and
// scores the resulting board for a win or a draw.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high; forces IDLE
//   new_game     in   level; restarts the game from WAIT or DONE
//   p_req/p_loc  in   player request (held until p_ack) and target cell
//   p_ack        out  one-cycle accept pulse for the player
//   c_req/c_loc  in   CPU request (held until c_ack) and target cell
//   c_ack        out  one-cycle accept pulse for the CPU
//   rej          out  one-cycle pulse when the served request is refused
//   board        in   cell states from the board
//   turn         in   board turn flag (TURN_PLAYER = X to move)
//   update_loc   out  cell index driven to the board
//   submit       out  strobe to the board; the board acts on its falling edge
//   board_reset  out  board reset; qualifies submit (1 = clear, 0 = move)
//   game_over    out  high in DONE
//   winner       out  CELL_X / CELL_O, or CELL_BLANK for a draw
//
// Build option
//   GAME_CTRL_TIMEOUT_EN  when defined, the player forfeits (winner = CELL_O)
//                         after TIMEOUT_CYCLES idle cycles in WAIT on X's turn.
//                         When undefined, WAIT waits indefinitely.
//
// Every output is a flop. Each one is loaded with the value it must show in
// the cycle after the current decision.
// -----------------------------------------------------------------------------

package game_ctrl_pkg;
    typedef logic [3:0]      INDEX_T;
    typedef logic [1:0]      STATE_T;
    typedef logic [8:0][1:0] BOARD_T;
    typedef logic            FLAG_T;

    localparam STATE_T CELL_BLANK  = 2'd0;
    localparam STATE_T CELL_X      = 2'd1;
    localparam STATE_T CELL_O      = 2'd2;

    localparam FLAG_T  TURN_PLAYER = 1'b0;
    localparam FLAG_T  TURN_CPU    = 1'b1;
endpackage

// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | start of a new game; raise submit with board_reset
// S_CLR_LO | submit is high; drop it with board_reset held, clearing board
// S_WAIT   | arbitrate the requester whose turn it is
// S_SUB_HI | ack is showing; raise submit for the latched move
// S_SUB_LO | submit high, then one settle cycle after its falling edge
// S_CHECK  | score the updated board: win, draw, or back to WAIT
// S_DONE   | game over; only new_game is honoured
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   new_game,
    input  logic   p_req,
    input  INDEX_T p_loc,
    output logic   p_ack,
    input  logic   c_req,
    input  INDEX_T c_loc,
    output logic   c_ack,
    output logic   rej,
    input  BOARD_T board,
    input  FLAG_T  turn,
    output INDEX_T update_loc,
    output FLAG_T  submit,
    output FLAG_T  board_reset,
    output logic   game_over,
    output STATE_T winner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR_LO,
        S_WAIT,
        S_SUB_HI,
        S_SUB_LO,
        S_CHECK,
        S_DONE
    } fsm_t;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("game_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    // Cell triplets for the 3 rows, 3 columns and 2 diagonals.
    localparam int NUM_LINES = 8;
    localparam logic [3:0] LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    fsm_t   state, state_d;
    logic   settle_q, settle_d;
    logic   p_ack_d, c_ack_d, rej_d;
    INDEX_T update_loc_d;
    FLAG_T  submit_d, board_reset_d;
    logic   game_over_d;
    STATE_T winner_d;

    logic   srv_req;
    INDEX_T srv_loc;
    logic   srv_free;
    STATE_T line_win;
    logic   full;
    logic   tmo_hit;

    function automatic STATE_T line_owner(input BOARD_T b);
        STATE_T owner;
        owner = CELL_BLANK;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (b[LINES[i][0]] != CELL_BLANK &&
                b[LINES[i][0]] == b[LINES[i][1]] &&
                b[LINES[i][1]] == b[LINES[i][2]])
                owner = b[LINES[i][0]];
        end
        return owner;
    endfunction

    function automatic logic board_full(input BOARD_T b);
        logic f;
        f = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (b[i] == CELL_BLANK)
                f = 1'b0;
        end
        return f;
    endfunction

    // Only the side whose turn it is gets looked at; the other request is
    // simply invisible, so it never produces a rej.
    always_comb begin
        srv_req  = (turn == TURN_PLAYER) ? p_req : c_req;
        srv_loc  = (turn == TURN_PLAYER) ? p_loc : c_loc;
        srv_free = 1'b0;
        if (srv_loc < 4'd9)
            srv_free = (board[srv_loc] == CELL_BLANK);
        line_win = line_owner(board);
        full     = board_full(board);
    end

`ifdef GAME_CTRL_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_run;

    // Down-counter: reloaded whenever the player is not the one being
    // waited on or the state is about to change.
    assign tmo_run = (state == S_WAIT) && (turn == TURN_PLAYER);
    assign tmo_hit = tmo_run && (tmo_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= TMO_LOAD;
        else if (tmo_run && (state_d == S_WAIT))
            tmo_cnt <= tmo_cnt - 1'b1;
        else
            tmo_cnt <= TMO_LOAD;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state;
        settle_d      = 1'b0;
        p_ack_d       = 1'b0;
        c_ack_d       = 1'b0;
        rej_d         = 1'b0;
        update_loc_d  = update_loc;
        submit_d      = 1'b0;
        board_reset_d = 1'b0;
        game_over_d   = game_over;
        winner_d      = winner;

        case (state)
            S_IDLE: begin
                submit_d      = 1'b1;
                board_reset_d = 1'b1;
                game_over_d   = 1'b0;
                winner_d      = CELL_BLANK;
                state_d       = S_CLR_LO;
            end

            S_CLR_LO: begin
                board_reset_d = 1'b1;
                state_d       = S_WAIT;
            end

            S_WAIT: begin
                if (new_game) begin
                    state_d = S_IDLE;
                end else if (srv_req && !rej) begin
                    // While rej is showing, the requester has not yet had a
                    // chance to drop its request. Skipping that cycle keeps
                    // it to a single rej per refused request.
                    if (srv_free) begin
                        p_ack_d      = (turn == TURN_PLAYER);
                        c_ack_d      = (turn != TURN_PLAYER);
                        update_loc_d = srv_loc;
                        state_d      = S_SUB_HI;
                    end else begin
                        rej_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    winner_d    = CELL_O;
                    game_over_d = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_SUB_HI: begin
                submit_d = 1'b1;
                state_d  = S_SUB_LO;
            end

            S_SUB_LO: begin
                // First pass drops submit; second pass is the settle cycle.
                if (settle_q) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = 1'b1;
                end
            end

            S_CHECK: begin
                if (line_win != CELL_BLANK) begin
                    winner_d    = line_win;
                    game_over_d = 1'b1;
                    state_d     = S_DONE;
                end else if (full) begin
                    winner_d    = CELL_BLANK;
                    game_over_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_DONE: begin
                if (new_game) begin
                    game_over_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            settle_q    <= 1'b0;
            p_ack       <= 1'b0;
            c_ack       <= 1'b0;
            rej         <= 1'b0;
            update_loc  <= '0;
            submit      <= 1'b0;
            board_reset <= 1'b0;
            game_over   <= 1'b0;
            winner      <= CELL_BLANK;
        end else begin
            state       <= state_d;
            settle_q    <= settle_d;
            p_ack       <= p_ack_d;
            c_ack       <= c_ack_d;
            rej         <= rej_d;
            update_loc  <= update_loc_d;
            submit      <= submit_d;
            board_reset <= board_reset_d;
            game_over   <= game_over_d;
            winner      <= winner_d;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
`timescale 1ns/1ps
module tb_game_ctrl;
    import game_ctrl_pkg::*;

    logic   clk      = 1'b0;
    logic   reset    = 1'b1;
    logic   new_game = 1'b0;
    logic   p_req    = 1'b0;
    logic   c_req    = 1'b0;
    INDEX_T p_loc    = '0;
    INDEX_T c_loc    = '0;
    logic   p_ack, c_ack, rej, game_over;
    INDEX_T update_loc;
    FLAG_T  submit, board_reset;
    STATE_T winner;

    // Board store model; starts dirty so the clear strobe is observable.
    BOARD_T board = '1;
    FLAG_T  turn  = TURN_CPU;

    game_ctrl #(.TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .p_req(p_req), .p_loc(p_loc), .p_ack(p_ack),
        .c_req(c_req), .c_loc(c_loc), .c_ack(c_ack),
        .rej(rej), .board(board), .turn(turn),
        .update_loc(update_loc), .submit(submit), .board_reset(board_reset),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    always @(negedge submit) begin
        if (board_reset) begin
            board <= '0;
            turn  <= TURN_PLAYER;
        end else if (update_loc < 4'd9) begin
            board[update_loc] <= (turn == TURN_PLAYER) ? CELL_X : CELL_O;
            turn              <= ~turn;
        end
    end

    typedef enum int {EV_PACK, EV_CACK, EV_REJ, EV_OVER} ev_kind_e;
    typedef struct { ev_kind_e kind; int val; } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  sub_mv   = 0;
    int  sub_clr  = 0;

    // Reference game: cell owners (0 blank, 1 X, 2 O) and whether it ended.
    int  cells[9];
    bit  ref_over = 1'b0;

    task automatic check_val(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    task automatic push_exp(input ev_kind_e k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input ev_kind_e k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got=%s/%0d expected=none", k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                failures++;
                $display("FAIL event got=%s/%0d expected=%s/%0d", k.name(), v, e.kind.name(), e.val);
            end
        end
    endtask

    function automatic int ref_winner();
        for (int k = 0; k < 3; k++) begin
            if (cells[3*k] != 0 && cells[3*k] == cells[3*k+1] && cells[3*k] == cells[3*k+2])
                return cells[3*k];
            if (cells[k] != 0 && cells[k] == cells[k+3] && cells[k] == cells[k+6])
                return cells[k];
        end
        if (cells[4] != 0 &&
            ((cells[0] == cells[4] && cells[8] == cells[4]) ||
             (cells[2] == cells[4] && cells[6] == cells[4])))
            return cells[4];
        return 0;
    endfunction

    function automatic int ref_filled();
        int n;
        n = 0;
        for (int i = 0; i < 9; i++)
            if (cells[i] != 0) n++;
        return n;
    endfunction

    // X always opens, so it is X's turn whenever an even number of cells is used.
    function automatic bit ref_player_turn();
        return (ref_filled() % 2) == 0;
    endfunction

    function automatic int rand_free();
        int fq[$];
        for (int i = 0; i < 9; i++)
            if (cells[i] == 0) fq.push_back(i);
        if (fq.size() == 0) return 0;
        return fq[$urandom_range(0, fq.size() - 1)];
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < 9; i++) cells[i] = 0;
        ref_over = 1'b0;
    endtask

    // Presents one request, holds it until answered (or a bounded time when
    // no answer is due) and checks the handshake and the move strobe count.
    task automatic do_req(input bit cpu, input int loc);
        bit expect_resp, accepted, seen;
        int mv0, w;
        accepted    = 1'b0;
        expect_resp = 1'b0;
        if (!ref_over && (cpu != ref_player_turn())) begin
            expect_resp = 1'b1;
            if (loc > 8 || cells[loc] != 0) begin
                push_exp(EV_REJ, 0);
            end else begin
                accepted   = 1'b1;
                push_exp(cpu ? EV_CACK : EV_PACK, loc);
                cells[loc] = cpu ? int'(CELL_O) : int'(CELL_X);
                w = ref_winner();
                if (w != 0) begin
                    push_exp(EV_OVER, w);
                    ref_over = 1'b1;
                end else if (ref_filled() == 9) begin
                    push_exp(EV_OVER, int'(CELL_BLANK));
                    ref_over = 1'b1;
                end
            end
        end
        mv0 = sub_mv;
        @(posedge clk); #1;
        if (cpu) begin c_req = 1'b1; c_loc = INDEX_T'(loc); end
        else     begin p_req = 1'b1; p_loc = INDEX_T'(loc); end
        seen = 1'b0;
        for (int t = 0; t < (expect_resp ? 20 : 10) && !seen; t++) begin
            @(negedge clk);
            if ((cpu ? c_ack : p_ack) || rej) seen = 1'b1;
        end
        @(posedge clk); #1;
        p_req = 1'b0;
        c_req = 1'b0;
        repeat (6) @(negedge clk);
        check_val(cpu ? "c_handshake" : "p_handshake", int'(seen), int'(expect_resp));
        check_val("move_submits", sub_mv - mv0, accepted ? 1 : 0);
    endtask

    task automatic start_new_game();
        int clr0;
        clr0 = sub_clr;
        @(posedge clk); #1;
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        ref_clear();
        repeat (5) @(negedge clk);
        check_val("clear_submits", sub_clr - clr0, 1);
        check_val("ng_game_over", int'(game_over), 0);
        check_val("ng_board_blank", int'(board), 0);
        check_val("ng_winner", int'(winner), int'(CELL_BLANK));
    endtask

    initial begin : monitor
        bit go_prev, sub_prev;
        go_prev  = 1'b0;
        sub_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (p_ack) check_event(EV_PACK, int'(update_loc));
                if (c_ack) check_event(EV_CACK, int'(update_loc));
                if (rej)   check_event(EV_REJ, 0);
                if (game_over && !go_prev) check_event(EV_OVER, int'(winner));
                if (submit) begin
                    check_val("submit_width", int'(sub_prev), 0);
                    if (board_reset) sub_clr++;
                    else             sub_mv++;
                end
            end
            go_prev  = game_over;
            sub_prev = submit;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "tb_game_ctrl watchdog expired");
    end

    initial begin : stim
        int  exp_go, n, r, loc;
        bit  tmo_build, cpu, ply;
`ifdef GAME_CTRL_TIMEOUT_EN
        tmo_build = 1'b1;
`else
        tmo_build = 1'b0;
`endif
        ref_clear();

        repeat (3) @(posedge clk); #1;
        check_val("rst_submit", int'(submit), 0);
        check_val("rst_board_reset", int'(board_reset), 0);
        check_val("rst_update_loc", int'(update_loc), 0);
        check_val("rst_acks", int'({p_ack, c_ack, rej}), 0);
        check_val("rst_game_over", int'(game_over), 0);
        check_val("rst_winner", int'(winner), int'(CELL_BLANK));
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_val("boot_clear_submits", sub_clr, 1);
        check_val("boot_board_blank", int'(board), 0);
        check_val("boot_turn", int'(turn), int'(TURN_PLAYER));
        check_val("boot_game_over", int'(game_over), 0);

        do_req(1'b0, 4);
        do_req(1'b1, 0);
        check_val("cell4_x", int'(board[4]), int'(CELL_X));
        check_val("cell0_o", int'(board[0]), int'(CELL_O));
`ifndef GAME_CTRL_TIMEOUT_EN
        do_req(1'b0, 4);
        do_req(1'b0, 9);
        do_req(1'b1, 5);
`endif
        do_req(1'b0, 8);
        do_req(1'b1, 0);
        do_req(1'b1, 12);
        start_new_game();

        do_req(1'b0, 0);
        do_req(1'b1, 3);
        do_req(1'b0, 1);
        do_req(1'b1, 4);
        do_req(1'b0, 2);
        check_val("xwin_game_over", int'(game_over), 1);
        do_req(1'b0, 5);
        do_req(1'b1, 5);
        start_new_game();

        do_req(1'b0, 0); do_req(1'b1, 1); do_req(1'b0, 2);
        do_req(1'b1, 4); do_req(1'b0, 3); do_req(1'b1, 5);
        do_req(1'b0, 7); do_req(1'b1, 6); do_req(1'b0, 8);
        check_val("draw_game_over", int'(game_over), 1);
        check_val("draw_winner", int'(winner), int'(CELL_BLANK));
        start_new_game();

`ifdef GAME_CTRL_TIMEOUT_EN
        push_exp(EV_OVER, int'(CELL_O));
        ref_over = 1'b1;
        exp_go   = 1;
`else
        exp_go   = 0;
`endif
        repeat (100) @(negedge clk);
        check_val("idle_game_over", int'(game_over), exp_go);
        start_new_game();

        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (!ref_over && n < 60) begin
                n++;
                ply = ref_player_turn();
                r   = $urandom_range(0, 99);
                if (tmo_build && ply) begin
                    cpu = 1'b0;
                    loc = rand_free();
                end else begin
                    cpu = (r < 15) ? ply : !ply;
                    if (tmo_build && !cpu && ply) cpu = 1'b0;
                    loc = ($urandom_range(0, 99) < 30) ? $urandom_range(0, 11) : rand_free();
                end
                do_req(cpu, loc);
            end
            do_req($urandom_range(0, 1) == 1, $urandom_range(0, 8));
            start_new_game();
        end

        repeat (4) @(negedge clk);
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
